// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants for the multiplexed 7-segment scan controller.
//   NUM_DIG      : digits scanned per frame
//   NIB_W/SEG_W  : hex nibble width and segment vector width
//   SEG_LSB_A/SEG_MSB_G : segment vector is {g,f,e,d,c,b,a}, a at bit 0
//   SEG_TAB      : active-high segment pattern for hex 0..F
//   scan_st_e    : slot phase (dead-time gap vs. driving the digit)
package seg_pkg;

  localparam int NUM_DIG   = 6;
  localparam int NIB_W     = 4;
  localparam int SEG_W     = 7;
  localparam int SEG_LSB_A = 0;
  localparam int SEG_MSB_G = 6;

  localparam logic [SEG_W-1:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_DRIVE = 1'b1
  } scan_st_e;

endpackage

// File: rtl/seg_scan_ctrl_hex_dec.sv
// seg_hex_dec -- combinational hex nibble to 7-segment decoder.
//   i_nib : 4-bit hex value
//   o_seg : segments {g,f,e,d,c,b,a}, active-high
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg[SEG_MSB_G:SEG_LSB_A] = SEG_TAB[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed scan of a 6-digit 7-segment display with
// per-digit dead time, blanking, blinking and frame-synchronous shadow update.
//   clk, rst         : system clock, async active-high reset
//   i_data           : six hex nibbles, digit k = i_data[4k+3:4k]
//   i_dp_mask        : decimal point per digit
//   i_blank_mask     : 1 = digit dark
//   i_blink_mask     : 1 = digit blinks
//   i_upd_req        : level request to load inputs into shadow at frame end
//   o_upd_ack        : one-cycle pulse after a shadow load
//   o_seg_enb        : one-hot digit enable
//   o_seg_dp, o_seg  : decimal point and segments {g..a}
//
// Slot phase (decoded from the slot counter):
//   state    | meaning
//   ST_GAP   | counter < GAP_CYC, all drives off (ghosting dead time)
//   ST_DRIVE | counter >= GAP_CYC, selected digit driven unless dark
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int DIGIT_HZ = 6000,
  parameter int GAP_CYC  = 50,
  parameter int BLINK_HZ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_DIG*NIB_W-1:0] i_data,
  input  logic [NUM_DIG-1:0]       i_dp_mask,
  input  logic [NUM_DIG-1:0]       i_blank_mask,
  input  logic [NUM_DIG-1:0]       i_blink_mask,
  input  logic                     i_upd_req,
  output logic                     o_upd_ack,
  output logic [NUM_DIG-1:0]       o_seg_enb,
  output logic                     o_seg_dp,
  output logic [SEG_W-1:0]         o_seg
);

  localparam int DIG_CYC = CLK_HZ / DIGIT_HZ;
  localparam int BLK_CYC = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W   = (DIG_CYC > 1) ? $clog2(DIG_CYC) : 1;
  localparam int BLK_W   = (BLK_CYC > 1) ? $clog2(BLK_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYC);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLK_CYC - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIG - 1);

  // run_q holds everything at its reset value until the first edge after
  // reset release, so that edge starts slot 0 at counter 0.
  logic                     run_q, run_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [2:0]               idx_q, idx_d;
  logic [BLK_W-1:0]         blk_cnt_q, blk_cnt_d;
  logic                     blk_on_q, blk_on_d;
  logic                     slot_on_q, slot_on_d;
  logic [NUM_DIG*NIB_W-1:0] sh_data_q, sh_data_d;
  logic [NUM_DIG-1:0]       sh_dp_q, sh_dp_d;
  logic [NUM_DIG-1:0]       sh_blank_q, sh_blank_d;
  logic [NUM_DIG-1:0]       sh_blink_q, sh_blink_d;
  logic                     ack_q, ack_d;
  logic [NUM_DIG-1:0]       enb_q, enb_d;
  logic                     dp_q, dp_d;
  logic [SEG_W-1:0]         seg_q, seg_d;

  logic                     frame_end;
  scan_st_e                 st_d;
  logic                     dark;
  logic [NIB_W-1:0]         nib_sel;
  logic [SEG_W-1:0]         dec_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      blk_cnt_q  <= BLK_LOAD;
      blk_on_q   <= 1'b1;
      slot_on_q  <= 1'b1;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      sh_blink_q <= '0;
      ack_q      <= 1'b0;
      enb_q      <= '0;
      dp_q       <= 1'b0;
      seg_q      <= '0;
    end else begin
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      blk_cnt_q  <= blk_cnt_d;
      blk_on_q   <= blk_on_d;
      slot_on_q  <= slot_on_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sh_blink_q <= sh_blink_d;
      ack_q      <= ack_d;
      enb_q      <= enb_d;
      dp_q       <= dp_d;
      seg_q      <= seg_d;
    end
  end

  // Timing, blink phase and shadow update.
  always_comb begin
    run_d      = 1'b1;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    blk_cnt_d  = blk_cnt_q;
    blk_on_d   = blk_on_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    sh_blink_d = sh_blink_q;
    ack_d      = 1'b0;
    frame_end  = run_q && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

    if (!run_q) begin
      cnt_d     = '0;
      idx_d     = '0;
      blk_cnt_d = BLK_LOAD;
      blk_on_d  = 1'b1;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (blk_cnt_q == '0) begin
        blk_cnt_d = BLK_LOAD;
        blk_on_d  = ~blk_on_q;
      end else begin
        blk_cnt_d = blk_cnt_q - BLK_W'(1);
      end
    end

    // Blink phase is latched at slot start so a digit is dark or lit for a
    // whole slot even when the toggle lands mid-slot.
    slot_on_d = (cnt_d == '0) ? blk_on_d : slot_on_q;

    if (frame_end && i_upd_req) begin
      sh_data_d  = i_data;
      sh_dp_d    = i_dp_mask;
      sh_blank_d = i_blank_mask;
      sh_blink_d = i_blink_mask;
      ack_d      = 1'b1;
    end
  end

  assign nib_sel = sh_data_d[{idx_d, 2'b00} +: NIB_W];

  seg_hex_dec u_hex_dec (
    .i_nib (nib_sel),
    .o_seg (dec_seg)
  );

  // Outputs are computed from next-state values so the registered drives
  // line up with the counter/index of the same cycle.
  always_comb begin
    st_d  = (cnt_d < CNT_GAP) ? ST_GAP : ST_DRIVE;
    dark  = sh_blank_d[idx_d] | (sh_blink_d[idx_d] & ~slot_on_d);
    enb_d = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (st_d == ST_DRIVE && !dark) begin
      enb_d = NUM_DIG'(1) << idx_d;
      seg_d = dec_seg;
      dp_d  = sh_dp_d[idx_d];
    end
  end

  assign o_upd_ack = ack_q;
  assign o_seg_enb = enb_q;
  assign o_seg_dp  = dp_q;
  assign o_seg     = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed frame/update/blink/blank/reset scenarios
// followed by randomized update traffic, all checked cycle by cycle against a
// frame-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int CLK_HZ   = 1200;
  localparam int DIGIT_HZ = 120;
  localparam int GAP      = 2;
  localparam int BLINK_HZ = 10;
  localparam int DIG      = CLK_HZ / DIGIT_HZ;          // 10 cycles per slot
  localparam int FRAME    = 6 * DIG;                    // 60 cycles per frame
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);    // 60 cycles per blink phase

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] i_data = '0;
  logic [5:0]  i_dp_mask = '0, i_blank_mask = '0, i_blink_mask = '0;
  logic        i_upd_req = 1'b0;
  logic        o_upd_ack;
  logic [5:0]  o_seg_enb;
  logic        o_seg_dp;
  logic [6:0]  o_seg;

  seg_scan_ctrl #(
    .CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .GAP_CYC(GAP), .BLINK_HZ(BLINK_HZ)
  ) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_dp_mask(i_dp_mask),
    .i_blank_mask(i_blank_mask), .i_blink_mask(i_blink_mask),
    .i_upd_req(i_upd_req), .o_upd_ack(o_upd_ack), .o_seg_enb(o_seg_enb),
    .o_seg_dp(o_seg_dp), .o_seg(o_seg)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = -1;

  // reference model: shadow contents and pending ack
  logic [23:0] m_data;
  logic [5:0]  m_dp, m_blank, m_blink;
  logic        m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0; m_ack = 1'b0;
    cyc = -1;
  endtask

  task automatic check_outputs();
    int off, slot;
    bit on, dark, drv;
    logic [3:0] nib;
    logic [5:0] e_enb;
    logic [6:0] e_seg;
    logic       e_dp;
    off  = cyc % DIG;
    slot = (cyc / DIG) % 6;
    on   = (((cyc - off) / HALF) % 2) == 0;
    dark = m_blank[slot] || (m_blink[slot] && !on);
    drv  = (off >= GAP) && !dark;
    nib  = m_data[slot*4 +: 4];
    e_enb = drv ? 6'(1 << slot) : 6'd0;
    e_seg = drv ? hex_tab[nib] : 7'd0;
    e_dp  = drv && m_dp[slot];
    chk("enb", 32'(o_seg_enb), 32'(e_enb));
    chk("seg", 32'(o_seg), 32'(e_seg));
    chk("dp",  32'(o_seg_dp), 32'(e_dp));
    chk("ack", 32'(o_upd_ack), 32'(m_ack));
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  // Model the frame-end edge that closes the current cycle.
  task automatic end_cycle();
    if ((cyc % FRAME) == FRAME - 1 && i_upd_req) begin
      m_data = i_data; m_dp = i_dp_mask; m_blank = i_blank_mask; m_blink = i_blink_mask;
      m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_enb", 32'(o_seg_enb), 32'd0);
    chk("rst_seg", 32'(o_seg), 32'd0);
    chk("rst_dp",  32'(o_seg_dp), 32'd0);
    chk("rst_ack", 32'(o_upd_ack), 32'd0);
    i_data = '0; i_dp_mask = '0; i_blank_mask = '0; i_blink_mask = '0; i_upd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int hold;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("por_enb", 32'(o_seg_enb), 32'd0);
    chk("por_seg", 32'(o_seg), 32'd0);
    chk("por_ack", 32'(o_upd_ack), 32'd0);
    rst = 1'b0;

    // pending request aborted by a reset in the middle of digit 2's slot
    for (int k = 0; k < 25; k++) begin
      tick();
      if (cyc == 5) begin i_data = 24'h123456; i_upd_req = 1'b1; end
      end_cycle();
    end
    tick();
    do_reset();

    // directed: first load, blink on digit 0, then blank digit 2 / dp on digit 1
    while (cyc < 419) begin
      tick();
      case (cyc)
        5:   begin i_data = 24'h123456; i_upd_req = 1'b1; end
        60:  i_upd_req = 1'b0;
        130: begin i_blink_mask = 6'b000001; i_upd_req = 1'b1; end
        180: i_upd_req = 1'b0;
        300: begin
          i_blink_mask = 6'b0; i_blank_mask = 6'b000100; i_dp_mask = 6'b000010;
          i_upd_req = 1'b1;
        end
        360: i_upd_req = 1'b0;
        default: ;
      endcase
      end_cycle();
    end

    // randomized traffic: held, single-shot and abandoned requests
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (k == 1500 + int'($urandom_range(0, 9))) begin
        do_reset();
        hold = 0;
        continue;
      end
      if (!i_upd_req) begin
        if ($urandom_range(0, 29) == 0) begin
          i_data       = 24'($urandom);
          i_dp_mask    = 6'($urandom);
          i_blank_mask = 6'($urandom) & 6'($urandom);
          i_blink_mask = 6'($urandom);
          i_upd_req    = 1'b1;
          hold         = int'($urandom_range(0, 2));
        end
      end else if (m_ack) begin
        if (hold == 0) i_upd_req = 1'b0;
        else hold--;
      end else if ($urandom_range(0, 299) == 0) begin
        i_upd_req = 1'b0;
      end
      end_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: input clock frequency.
REQ-002 Parameter DIGIT_HZ, default 6000: digit-slot rate; DIG_CYC = CLK_HZ/DIGIT_HZ cycles per slot.
REQ-003 Parameter GAP_CYC, default 50: dead-time cycles at slot start, enables off; GAP_CYC < DIG_CYC.
REQ-004 Parameter BLINK_HZ, default 2: blink rate; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge system clock.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 i_data  in  24  six hex nibbles; digit k = i_data[4k+3:4k].
REQ-009 i_dp_mask  in  6  decimal point per digit, bit k = digit k.
REQ-010 i_blank_mask  in  6  1 = digit k dark.
REQ-011 i_blink_mask  in  6  1 = digit k blinks.
REQ-012 i_upd_req  in  1  level request to load all inputs into shadow registers.
REQ-013 o_upd_ack  out  1  one-cycle pulse: shadow load performed.
REQ-014 o_seg_enb  out  6  one-hot digit enable, active-high.
REQ-015 o_seg_dp  out  1  decimal point, active-high.
REQ-016 o_seg  out  7  segments {g,f,e,d,c,b,a}, active-high.

Function
REQ-017 Slot counter 0..DIG_CYC-1 and digit index 0..5 SHALL advance every cycle; index wraps 5->0 when counter wraps.
REQ-018 Counter < GAP_CYC: o_seg_enb, o_seg, o_seg_dp SHALL all be 0 (GAP state).
REQ-019 Counter >= GAP_CYC: o_seg_enb SHALL be one-hot at index, o_seg = hex decode of shadow nibble, o_seg_dp = shadow dp bit (DRIVE state).
REQ-020 All outputs SHALL be registered; values reflect counter/index state of the same cycle (no extra latency).
REQ-021 Hex decode SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-022 Blanked digit (shadow blank bit), or blinking digit while blink phase = off: enb, seg, dp SHALL stay 0 for the whole slot; slot time still consumed.
REQ-023 Blink phase SHALL reset to on and toggle free-running, independent of slot timing.
REQ-024 Frame end = last cycle of digit 5 slot; shadow registers SHALL change only there.
REQ-025 i_upd_req high at frame end: inputs sampled that cycle into shadow, o_upd_ack = 1 next cycle for exactly one cycle.
REQ-026 i_upd_req low at frame end: no load, no ack; request dropped before frame end is discarded.
REQ-027 i_upd_req held after ack: reload and re-ack at each subsequent frame end.
REQ-028 Inputs SHALL be held stable by requester from request to ack.

Reset
REQ-029 rst asserted: counter, index, shadow data/dp/blank/blink SHALL clear to 0, blink phase on, all outputs 0, immediately (asynchronous).
REQ-030 After rst release, first edge starts slot 0 counter 0 (GAP); reset mid-slot or mid-request aborts with no ack.

Structure
REQ-031 Package seg_pkg SHALL hold the 16-entry segment table, digit count (6), and segment bit ordering constants.
REQ-032 Sub-module seg_hex_dec (4-bit in, 7-bit out, combinational) SHALL implement REQ-021; the scan controller registers its output.

Verification (CLK_HZ=1200, DIGIT_HZ=120 -> DIG_CYC=10, GAP_CYC=2, BLINK_HZ=10 -> toggle every 60 cycles)
REQ-033 Reset release -> cycles 0-1 enb=000000; cycles 2-9 enb=000001, seg=3F, dp=0; cycles 12-19 enb=000010; frame repeats at cycle 60.
REQ-034 i_data=24'h123456, i_upd_req=1 at cycle 5 -> o_upd_ack pulse at cycle 60 only; cycles 62-69 seg=7D (digit 0 = 6); cycles 112-119 enb=100000, seg=06.
REQ-035 After load, i_blink_mask=000001 with update -> digit 0 dark in frames during blink-off (cycles 60-119 offset), lit during blink-on; other digits unaffected.
REQ-036 i_blank_mask=000100, i_dp_mask=000010 loaded -> digit 2 slot enb=0, seg=0; digit 1 slot dp=1, all other dp=0.
REQ-037 rst asserted at cycle 25 mid-request -> all outputs 0 same cycle, no ack; after release output sequence restarts per REQ-033 with seg=3F.
